// File: rtl/json_array_tx.sv
// json_array_tx: streams signed integer elements out as compact JSON array
// text, one ASCII byte per output handshake. Each accepted element is turned
// into BCD by a fixed-length double-dabble pass, then emitted as an optional
// '[' or ',', an optional '-', and its decimal digits. Leading zeros are
// suppressed. A closing ']' with m_last follows the element marked s_last.
//
// Optional feature: define JSON_ARRAY_TX_PRETTY_EN to emit a space after
// every comma through an extra SPACE state.
module json_array_tx #(
  parameter int VALUE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [VALUE_W-1:0] s_data,
  input  logic               s_last,
  input  logic               s_empty,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [7:0]         m_data,
  output logic               m_last
);

  localparam int CNT_W  = $clog2(VALUE_W + 1);
  localparam int DIGITS = 10;
  localparam int BCD_W  = 4 * DIGITS;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    OPEN,
    SEP,
`ifdef JSON_ARRAY_TX_PRETTY_EN
    SPACE,
`endif
    SIGN,
    DIGIT,
    CLOSE
  } state_t;

  state_t             state_q, state_d;
  logic               first_q;   // next element opens a new array
  logic               rdy_en_q;  // holds s_ready low until the first edge out of reset
  logic               neg_q;
  logic               last_q;
  logic               empty_q;
  logic [VALUE_W-1:0] bin_q;     // magnitude, shifted out MSB first during CONV
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         dig_q;     // index of the digit currently on m_data

  logic               accept;
  logic               fire;
  logic [VALUE_W-1:0] mag;
  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         msd;
  logic [3:0]         digit;
  state_t             value_start;

  assign accept  = s_valid && s_ready;
  assign fire    = m_valid && m_ready;
  assign s_ready = rdy_en_q && (state_q == IDLE);

  // Two's-complement negate; the most-negative value maps onto 2^(VALUE_W-1),
  // which still fits in VALUE_W unsigned bits.
  assign mag = s_data[VALUE_W-1] ? -s_data : s_data;

  // First byte of the value proper, after the '[' / ',' (and space).
  assign value_start = neg_q ? SIGN : DIGIT;

  // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Most significant non-zero digit (0 when the whole value is zero) and the
  // digit selected by dig_q.
  always_comb begin
    msd   = 4'd0;
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = 4'(i);
      if (dig_q == 4'(i)) digit = bcd_q[4*i +: 4];
    end
  end

  // Next-state and output decode; outputs depend only on registered state,
  // so they hold steady while the sink stalls.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (s_empty && s_last) ? OPEN : CONV;
      end
      CONV: begin
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = first_q ? OPEN : SEP;
      end
      OPEN: begin
        m_valid = 1'b1;
        m_data  = 8'h5B;
        if (fire) state_d = empty_q ? CLOSE : value_start;
      end
      SEP: begin
        m_valid = 1'b1;
        m_data  = 8'h2C;
`ifdef JSON_ARRAY_TX_PRETTY_EN
        if (fire) state_d = SPACE;
`else
        if (fire) state_d = value_start;
`endif
      end
`ifdef JSON_ARRAY_TX_PRETTY_EN
      SPACE: begin
        m_valid = 1'b1;
        m_data  = 8'h20;
        if (fire) state_d = value_start;
      end
`endif
      SIGN: begin
        m_valid = 1'b1;
        m_data  = 8'h2D;
        if (fire) state_d = DIGIT;
      end
      DIGIT: begin
        m_valid = 1'b1;
        m_data  = {4'h3, digit};
        if (fire && dig_q == 4'd0) state_d = last_q ? CLOSE : IDLE;
      end
      CLOSE: begin
        m_valid = 1'b1;
        m_data  = 8'h5D;
        m_last  = 1'b1;
        if (fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and array-framing flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      first_q  <= 1'b1;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      if (state_q == DIGIT && state_d == IDLE) first_q <= 1'b0;
      if (state_q == CLOSE && state_d == IDLE) first_q <= 1'b1;
    end
  end

  // Element capture, double-dabble conversion and digit walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q   <= 1'b0;
      last_q  <= 1'b0;
      empty_q <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= 4'd0;
    end else begin
      if (state_q == IDLE && accept) begin
        neg_q   <= s_data[VALUE_W-1];
        last_q  <= s_last;
        empty_q <= s_empty && s_last;
        bin_q   <= mag;
        bcd_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == CONV) begin
        bcd_q <= (bcd_adj << 1) | BCD_W'(bin_q[VALUE_W-1]);
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Outside DIGIT track the leading digit so DIGIT starts on it;
      // the BCD buffer is already final by the time any output state runs.
      if (state_q != DIGIT) dig_q <= msd;
      else if (fire)        dig_q <= dig_q - 4'd1;
    end
  end

endmodule

// File: tb/tb_json_array_tx.sv
// Self-checking bench for json_array_tx (VALUE_W = 32). Expected text is
// produced by formatting the element list as decimal JSON with $sformatf.
module tb_json_array_tx;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         s_empty;
  logic         m_valid;
  logic         m_ready;
  logic [7:0]   m_data;
  logic         m_last;

  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  bit  rand_ready  = 1'b0;

  int  elems[$];
  bit  arr_empty;
  byte got_q[$];
  int  t_acc;
  int  t_first;

  json_array_tx #(.VALUE_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_empty (s_empty),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink: full rate, or a random ready pattern when rand_ready is set.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic string model();
    string s;
    if (arr_empty) return "[]";
    s = "[";
    foreach (elems[i]) begin
`ifdef JSON_ARRAY_TX_PRETTY_EN
      if (i > 0) s = {s, ", "};
`else
      if (i > 0) s = {s, ","};
`endif
      s = {s, $sformatf("%0d", elems[i])};
    end
    return {s, "]"};
  endfunction

  task automatic drive_elem(input int v, input bit last, input bit empty_flag,
                            output bit ok, output int t);
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = v;
    s_last  = last;
    s_empty = empty_flag;
    ok = 1'b0;
    t  = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = $urandom;
    s_last  = 1'($urandom);
    s_empty = 1'($urandom);
  endtask

  // Capture handshaked bytes until m_last (or max_bytes when non-zero),
  // checking that a stalled byte stays put and m_last marks only ']'.
  task automatic collect(input int max_bytes);
    bit       prev_stall = 1'b0;
    logic [7:0] pd = 8'h00;
    logic     pl = 1'b0;
    bit       done = 1'b0;
    got_q   = {};
    t_first = -1;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(negedge clk);
      if (prev_stall) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                   m_valid, m_data, m_last, pd, pl);
        end
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (m_valid && t_first < 0) t_first = cyc;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        vectors++;
        if (m_last !== (m_data == 8'h5D)) begin
          miscompares++;
          $display("FAIL m_last_flag: byte %h with m_last=%b", m_data, m_last);
        end
        if (m_last || (max_bytes > 0 && got_q.size() == max_bytes)) done = 1'b1;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL collect_timeout: %0d bytes seen", got_q.size());
    end
  endtask

  task automatic check_str(input string name, input string exp);
    string s = "";
    bit    bad;
    foreach (got_q[i]) s = {s, $sformatf("%c", got_q[i])};
    bad = (got_q.size() != exp.len());
    for (int i = 0; i < exp.len() && !bad; i++) if (got_q[i] != exp[i]) bad = 1'b1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got \"%s\" need \"%s\"", name, s, exp);
    end
  endtask

  task automatic run_array(input string name);
    string exp = model();
    int    lat;
    fork
      begin
        bit ok;
        int t;
        for (int i = 0; i < elems.size(); i++) begin
          bit last = (i == elems.size() - 1);
          bit emp  = arr_empty ? 1'b1 : (last ? 1'b0 : 1'($urandom_range(0, 1)));
          drive_elem(arr_empty ? int'($urandom) : elems[i], last, emp, ok, t);
          if (i == 0) t_acc = t;
          if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_accept_timeout: element %0d", name, i);
            break;
          end
        end
      end
      collect(0);
    join
    check_str(name, exp);
    lat = arr_empty ? 1 : W + 1;
    vectors++;
    if (t_first - t_acc !== lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles need %0d", name, t_first - t_acc, lat);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got valid=%b ready=%b data=%h last=%b need 0 0 00 0",
               name, m_valid, s_ready, m_data, m_last);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_empty = 1'b0;
    #2;
    check_idle_outputs("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b need 1", s_ready);
    end
  endtask

  task automatic test_single();
    rand_ready = 1'b0;
    arr_empty  = 1'b0;
    elems      = '{5};
    run_array("single_5");
  endtask

  task automatic test_extremes();
    rand_ready = 1'b0;
    arr_empty  = 1'b0;
    elems      = '{0, -1, 2147483647, int'(32'h8000_0000)};
    run_array("extremes");
  endtask

  task automatic test_empty();
    rand_ready = 1'b0;
    arr_empty  = 1'b1;
    elems      = '{0};
    run_array("empty_array");
  endtask

  task automatic test_back_to_back();
    rand_ready = 1'b0;
    arr_empty  = 1'b0;
    elems = '{12, -305};      run_array("b2b_a");
    elems = '{-9};            run_array("b2b_b");
    elems = '{100000, 10, 0}; run_array("b2b_c");
  endtask

  task automatic test_backpressure();
    rand_ready = 1'b1;
    arr_empty  = 1'b0;
    elems      = '{-40};
    run_array("backpressure_m40");
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    rand_ready = 1'b0;
    elems      = '{1};
    arr_empty  = 1'b0;
    fork
      drive_elem(1, 1'b0, 1'b0, ok, t);
      collect(2);
    join
    check_str("reset_mid_prefix", "[1");
    drive_elem(2, 1'b0, 1'b0, ok, t);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    elems = '{7};
    run_array("after_reset_7");
  endtask

  task automatic test_random();
    for (int a = 0; a < 20; a++) begin
      int n = $urandom_range(1, 6);
      rand_ready = 1'($urandom_range(0, 1));
      arr_empty  = ($urandom_range(0, 9) == 0);
      elems      = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: elems.push_back(int'($urandom));
          1: elems.push_back($urandom_range(0, 200) - 100);
          2: elems.push_back(($urandom_range(0, 1) != 0) ? 2147483647 : int'(32'h8000_0000));
          default: elems.push_back(int'($urandom) >>> $urandom_range(0, 31));
        endcase
      end
      if (arr_empty) elems = '{0};
      run_array($sformatf("random_%0d", a));
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_empty();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
